// File: rtl/prores_hdr_pkg.sv
// Constants, state and error encodings for the ProRes frame header,
// shared by the header generator and the header parser.
package prores_hdr_pkg;

    localparam logic [31:0] HDR_SIGNATURE   = 32'h69637066;  // "icpf"
    localparam int          FIXED_HDR_BYTES = 28;
    localparam logic [15:0] MIN_HDR_SIZE    = 16'd20;
    localparam logic [15:0] QMAT_BYTES      = 16'd64;
    localparam logic [5:0]  QMAT_LAST       = 6'd63;

    // Offset of the final byte of each field within the header
    localparam logic [7:0] OFS_FRAME_SIZE_LAST = 8'd3;
    localparam logic [7:0] OFS_SIG_LAST        = 8'd7;
    localparam logic [7:0] OFS_HDR_SIZE_LAST   = 8'd9;
    localparam logic [7:0] OFS_HORIZ_LAST      = 8'd17;
    localparam logic [7:0] OFS_VERT_LAST       = 8'd19;
    localparam logic [7:0] OFS_FORMAT          = 8'd20;
    localparam logic [7:0] OFS_RATE            = 8'd21;
    localparam logic [7:0] OFS_PRIMARIES       = 8'd22;
    localparam logic [7:0] OFS_TRANSFER        = 8'd23;
    localparam logic [7:0] OFS_MATRIX          = 8'd24;
    localparam logic [7:0] OFS_PIXFMT          = 8'd25;
    localparam logic [7:0] OFS_FLAGS           = 8'(FIXED_HDR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIXED = 3'd1,
        ST_YQ    = 3'd2,
        ST_CQ    = 3'd3,
        ST_SKIP  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } hdr_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_SIG  = 2'd1,
        ERR_HDR_SIZE = 2'd2
    } hdr_err_e;

endpackage

// File: rtl/prores_frame_header_parser.sv
// Byte-serial ProRes frame header parser: validates the header, extracts its
// fields and streams the quantisation matrices into the consumer-side store.
//
// state | meaning
// IDLE  | waiting for byte 0 of a header
// FIXED | bytes 0-27, fixed fields and size/signature checks
// YQ    | 64 luma matrix bytes
// CQ    | 64 chroma matrix bytes
// SKIP  | trailing bytes up to hdr_size+8
// DONE  | header complete, fields valid, input held off
// ERR   | header rejected, input held off
module prores_frame_header_parser
    import prores_hdr_pkg::*;
#(
    parameter int QMAT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              hdr_valid,
    output logic              hdr_error,
    output logic [1:0]        err_code,
    output logic [31:0]       frame_size,
    output logic [15:0]       horizontal,
    output logic [15:0]       vertical,
    output logic [1:0]        chroma_format,
    output logic [1:0]        interlace_mode,
    output logic [3:0]        aspect_ratio_information,
    output logic [3:0]        frame_rate_code,
    output logic [7:0]        color_primaries,
    output logic [7:0]        transfer_characteristic,
    output logic [7:0]        matrix_coefficients,
    output logic [3:0]        src_pixel_format,
    output logic [3:0]        alpha_channel_type,
    output logic              load_luma_qmat,
    output logic              load_chroma_qmat,
    output logic              qmat_we,
    output logic              qmat_sel,
    output logic [5:0]        qmat_addr,
    output logic [QMAT_W-1:0] qmat_data
);

    hdr_state_e        r_state, w_state_nxt;
    hdr_err_e          r_err_code;
    logic [CNT_W-1:0]  r_cnt;
    logic [23:0]       r_shift;
    logic [15:0]       r_hdr_size;
    logic [15:0]       r_skip_left;
    logic [5:0]        r_qidx;
    logic [31:0]       r_frame_size;
    logic [15:0]       r_horizontal, r_vertical;
    logic [1:0]        r_chroma_format, r_interlace_mode;
    logic [3:0]        r_aspect, r_frame_rate, r_src_pixfmt, r_alpha;
    logic [7:0]        r_primaries, r_transfer, r_matrix;
    logic              r_load_luma, r_load_chroma;
    logic              r_qmat_we, r_qmat_sel;
    logic [5:0]        r_qmat_addr;
    logic [QMAT_W-1:0] r_qmat_data;

    logic              w_accept;
    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [1:0]        w_nmat;
    logic [15:0]       w_need;
    logic [15:0]       w_skip_init;
    logic              w_size_bad_late;

    assign w_word          = {r_shift, in_data};
    assign w_half          = {r_shift[7:0], in_data};
    assign w_nmat          = {1'b0, in_data[1]} + {1'b0, in_data[0]};
    assign w_need          = MIN_HDR_SIZE + {8'd0, w_nmat, 6'd0};
    assign w_size_bad_late = w_need > r_hdr_size;
    // Trailing byte count once fixed part and matrices are consumed; only
    // meaningful when the late size check passes, so it cannot underflow.
    assign w_skip_init     = r_hdr_size - w_need;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state != ST_DONE) && (r_state != ST_ERR);
        hdr_valid   = (r_state == ST_DONE);
        hdr_error   = (r_state == ST_ERR);
        w_accept    = in_valid && in_ready && !restart;

        if (restart) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_FIXED;
                ST_FIXED: begin
                    if (r_cnt[7:0] == OFS_SIG_LAST && w_word != HDR_SIGNATURE) begin
                        w_state_nxt = ST_ERR;
                    end else if (r_cnt[7:0] == OFS_HDR_SIZE_LAST && w_half < MIN_HDR_SIZE) begin
                        w_state_nxt = ST_ERR;
                    end else if (r_cnt[7:0] == OFS_FLAGS) begin
                        if (w_size_bad_late)       w_state_nxt = ST_ERR;
                        else if (in_data[1])       w_state_nxt = ST_YQ;
                        else if (in_data[0])       w_state_nxt = ST_CQ;
                        else if (w_skip_init == 0) w_state_nxt = ST_DONE;
                        else                       w_state_nxt = ST_SKIP;
                    end
                end
                ST_YQ: begin
                    if (r_qidx == QMAT_LAST) begin
                        if (r_load_chroma)         w_state_nxt = ST_CQ;
                        else if (r_skip_left == 0) w_state_nxt = ST_DONE;
                        else                       w_state_nxt = ST_SKIP;
                    end
                end
                ST_CQ: begin
                    if (r_qidx == QMAT_LAST) begin
                        w_state_nxt = (r_skip_left == 0) ? ST_DONE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (r_skip_left == 16'd1) w_state_nxt = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_code       <= ERR_NONE;
            r_cnt            <= '0;
            r_shift          <= '0;
            r_hdr_size       <= '0;
            r_skip_left      <= '0;
            r_qidx           <= '0;
            r_frame_size     <= '0;
            r_horizontal     <= '0;
            r_vertical       <= '0;
            r_chroma_format  <= '0;
            r_interlace_mode <= '0;
            r_aspect         <= '0;
            r_frame_rate     <= '0;
            r_primaries      <= '0;
            r_transfer       <= '0;
            r_matrix         <= '0;
            r_src_pixfmt     <= '0;
            r_alpha          <= '0;
            r_load_luma      <= 1'b0;
            r_load_chroma    <= 1'b0;
            r_qmat_we        <= 1'b0;
            r_qmat_sel       <= 1'b0;
            r_qmat_addr      <= '0;
            r_qmat_data      <= '0;
        end else if (restart) begin
            // Field registers deliberately keep their last values.
            r_err_code <= ERR_NONE;
            r_cnt      <= '0;
            r_qidx     <= '0;
            r_qmat_we  <= 1'b0;
        end else begin
            r_qmat_we <= 1'b0;
            if (w_accept) begin
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                r_shift <= {r_shift[15:0], in_data};
                if (r_state == ST_FIXED) begin
                    case (r_cnt[7:0])
                        OFS_FRAME_SIZE_LAST: r_frame_size <= w_word;
                        OFS_SIG_LAST: begin
                            if (w_word != HDR_SIGNATURE) r_err_code <= ERR_BAD_SIG;
                        end
                        OFS_HDR_SIZE_LAST: begin
                            r_hdr_size <= w_half;
                            if (w_half < MIN_HDR_SIZE) r_err_code <= ERR_HDR_SIZE;
                        end
                        OFS_HORIZ_LAST: r_horizontal <= w_half;
                        OFS_VERT_LAST:  r_vertical   <= w_half;
                        OFS_FORMAT: begin
                            r_chroma_format  <= in_data[7:6];
                            r_interlace_mode <= in_data[3:2];
                        end
                        OFS_RATE: begin
                            r_aspect     <= in_data[7:4];
                            r_frame_rate <= in_data[3:0];
                        end
                        OFS_PRIMARIES: r_primaries <= in_data;
                        OFS_TRANSFER:  r_transfer  <= in_data;
                        OFS_MATRIX:    r_matrix    <= in_data;
                        OFS_PIXFMT: begin
                            r_src_pixfmt <= in_data[7:4];
                            r_alpha      <= in_data[3:0];
                        end
                        OFS_FLAGS: begin
                            r_load_luma   <= in_data[1];
                            r_load_chroma <= in_data[0];
                            r_skip_left   <= w_skip_init;
                            if (w_size_bad_late) r_err_code <= ERR_HDR_SIZE;
                        end
                        default: ;
                    endcase
                end
                if (r_state == ST_YQ || r_state == ST_CQ) begin
                    r_qmat_we   <= 1'b1;
                    r_qmat_sel  <= (r_state == ST_CQ);
                    r_qmat_addr <= r_qidx;
                    r_qmat_data <= {{(QMAT_W-8){1'b0}}, in_data};
                    r_qidx      <= r_qidx + 1'b1;
                end
                if (r_state == ST_SKIP) r_skip_left <= r_skip_left - 1'b1;
            end
        end
    end

    assign err_code                 = r_err_code;
    assign frame_size               = r_frame_size;
    assign horizontal               = r_horizontal;
    assign vertical                 = r_vertical;
    assign chroma_format            = r_chroma_format;
    assign interlace_mode           = r_interlace_mode;
    assign aspect_ratio_information = r_aspect;
    assign frame_rate_code          = r_frame_rate;
    assign color_primaries          = r_primaries;
    assign transfer_characteristic  = r_transfer;
    assign matrix_coefficients      = r_matrix;
    assign src_pixel_format         = r_src_pixfmt;
    assign alpha_channel_type       = r_alpha;
    assign load_luma_qmat           = r_load_luma;
    assign load_chroma_qmat         = r_load_chroma;
    assign qmat_we                  = r_qmat_we;
    assign qmat_sel                 = r_qmat_sel;
    assign qmat_addr                = r_qmat_addr;
    assign qmat_data                = r_qmat_data;

endmodule

// File: doc/prores_frame_header_parser.md
Name: prores_frame_header_parser

Overview:
- Decoder-side counterpart of the frame header generator. Consumes the byte-serial ProRes frame header and checks the frame size word, the 'icpf' signature and the header size.
- Extracts every header field and writes the luma/chroma quantisation matrices into a consumer-side store.
- Sits between the input byte FIFO and the slice/picture parser. Hands off once the whole header, including trailing bytes, has been consumed.

Parameters:
- QMAT_W, 32, width of quantisation matrix write data (entries zero-extended from 8 bits)
- CNT_W, 16, width of the header byte counter

Ports:
- clock  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- restart  input  1  one-cycle pulse; abort or finish the current header and return to IDLE
- in_valid  input  1  in_data valid
- in_data  input  8  header byte, MSB-first bit order as transmitted
- in_ready  output  1  byte accepted when in_valid and in_ready are both 1
- hdr_valid  output  1  level; all field outputs are valid and stable
- hdr_error  output  1  level; header rejected
- err_code  output  2  0 none, 1 bad signature, 2 header size too small
- frame_size  output  32  frame size field
- horizontal, vertical  output  16 each  picture dimensions
- chroma_format, interlace_mode  output  2 each  header fields
- aspect_ratio_information, frame_rate_code  output  4 each  header fields
- color_primaries, transfer_characteristic, matrix_coefficients  output  8 each  header fields
- src_pixel_format, alpha_channel_type  output  4 each  header fields
- load_luma_qmat, load_chroma_qmat  output  1 each  matrix-present flags
- qmat_we  output  1  matrix entry write strobe
- qmat_sel  output  1  0 luma, 1 chroma
- qmat_addr  output  6  raster index, row*8+col
- qmat_data  output  QMAT_W  entry value

Behaviour:
- Reset values: all outputs 0, state IDLE; in_ready is 1 after reset.
- Byte offsets within the header:
  - 0-3 frame_size; 4-7 signature 0x69637066; 8-9 hdr_size; 10 reserved; 11 version; 12-15 encoder id (discarded)
  - 16-17 horizontal; 18-19 vertical
  - byte 20 = {chroma_format[7:6], reserved[5:4], interlace_mode[3:2], reserved[1:0]}
  - byte 21 = {aspect[7:4], frame_rate[3:0]}
  - 22 color_primaries; 23 transfer_characteristic; 24 matrix_coefficients
  - byte 25 = {src_pixel_format[7:4], alpha[3:0]}
  - 26 reserved
  - byte 27 = {reserved[7:2], load_luma[1], load_chroma[0]}
  - then 64 luma bytes if load_luma, then 64 chroma bytes if load_chroma.
- Total header length is hdr_size+8 bytes. A byte counter cnt increments on every accepted byte.
- States:
  - IDLE → FIXED on the first accepted byte.
  - FIXED accepts bytes 0-27. After byte 27 it goes to YQ if load_luma, else CQ if load_chroma, else SKIP.
  - YQ: 64 bytes, then CQ or SKIP.
  - CQ: 64 bytes, then SKIP.
  - SKIP discards bytes while cnt < hdr_size+8. It is skipped entirely if that length is already reached.
  - Then DONE.
- Field registers update on the clock edge that accepts their last byte. Multi-byte fields are big-endian.
- Signature check is made on byte 7. On mismatch: go to ERR, hdr_error=1, err_code=1.
- Header size check is made on byte 9. If hdr_size < 20, or the required length (20 + 64 × number of flagged matrices) exceeds hdr_size, go to ERR with err_code=2. The matrix part of this check is deferred to byte 27, because the flags are only known then.
- qmat writes: each matrix byte produces a registered qmat_we pulse on the following cycle, with addr equal to the byte index within the matrix. Matrix latency is 1 cycle.
- DONE: hdr_valid=1, in_ready=0, fields held until restart.
- ERR: in_ready=0, hdr_error held until restart.
- restart in any state:
  - next cycle goes to IDLE, clears hdr_valid, hdr_error, err_code, cnt and qmat_we; field registers keep their values;
  - restart has priority over a byte accepted in the same cycle, and that byte is dropped;
  - during YQ/CQ a partial matrix is left in the store; the consumer must ignore it because hdr_valid stays 0.
- in_valid low stalls the state machine in any state with no side effects.
- cnt saturates at 2^CNT_W-1. hdr_size 0xFFFF with CNT_W=16 is legal.

Decomposition:
- Package prores_hdr_pkg:
  - signature constant 0x69637066
  - byte offset constants
  - FIXED_HDR_BYTES=28
  - MIN_HDR_SIZE=20
  - state enum
  - err_code enum
- Shared with the generator side.
- No sub-module; the field extract is a case on cnt inside a single FSM module.

Test Plan:
- Header bytes 00 00 04 CA 69 63 70 66 00 94 00 00 4C 61 76 63 07 80 04 38 80 23 01 01 01 40 00 03, followed by 128 matrix bytes of value 4 → frame_size=0x4CA, horizontal=1920, vertical=1080, chroma_format=2, frame_rate_code=3, src_pixel_format=4, 128 qmat writes of data 4 (64 with sel=0 then 64 with sel=1), hdr_valid after byte 155.
- Same header with hdr_size=0x0014 and flags=0 → no qmat writes, no SKIP bytes, hdr_valid one cycle after byte 27.
- Signature byte 7 = 0x67 → hdr_error=1, err_code=1, in_ready=0, no further field updates.
- hdr_size=0x0050 with both flags=1 → err_code=2 after byte 27.
- Random in_valid gaps (50% duty) on the first vector → results identical to the gap-free run.
- restart pulsed at byte 60, then a full valid header → second header parsed correctly with hdr_valid=1; reset_n asserted mid-header → all outputs 0.
